fibonacci_engine: RTL and testbench
===================================

# fibonacci_engine

Parametrised, fully synchronous Fibonacci sequence engine computing F(n) for a requested index n under a start/busy/done handshake. It has one clock and uses no derived or gated clocks. It is the next-generation replacement for the fixed 16-bit calculator. It adds configurable result and index widths, an explicit state machine, a held result, and optional overflow detection.

## Interface
- DATA_W, 16, result width in bits (≥ 2)
- IDX_W, 5, index width in bits (≥ 1)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- n_in  input  IDX_W  requested index n; latched when start is accepted
- busy  output  1  high while computing (RUN)
- done  output  1  high in DONE; held until next accepted start
- fibo_out  output  DATA_W  F(n) mod 2^DATA_W; valid while done=1
- overflow  output  1  F(n) ≥ 2^DATA_W; valid while done=1

## Operation
- Sequence: F(0)=0, F(1)=1, F(k+2)=F(k+1)+F(k).
- Internal registers: a=F(k), b=F(k+1), k (IDX_W bits), n_q, and sticky flags ova and ovb marking wrap of a and b.
- States are IDLE, RUN and DONE.
- IDLE, start=1: load n_q←n_in, a←0, b←1, k←0, ova←0, ovb←0; go to RUN.
- RUN, k==n_q: fibo_out←a, overflow←ova; go to DONE.
- RUN, otherwise (one step per clock):
  - a←b
  - b←(a+b) mod 2^DATA_W
  - ova←ovb
  - ovb←ova|ovb|carry(a+b)
  - k←k+1
- DONE, start=1: same load as IDLE; go to RUN; done drops.
- DONE, start=0: hold fibo_out, overflow and done.
- start in RUN is ignored; n_in changes in RUN have no effect.
- Arithmetic uses a (DATA_W+1)-bit add; the carry feeds only the overflow logic.
- k cannot wrap, because the run ends at k==n_q ≤ 2^IDX_W−1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, busy=0, done=0, fibo_out=0, overflow=0; internal registers are cleared.
- Reset mid-RUN aborts immediately; no result is produced.
- Start accepted at edge E0: busy=1 after E0.
- done=1 and a valid result appear after edge E0+n+1; busy falls on that same edge.
- Latency is n+1 cycles from start acceptance to done, with n=0 giving 1 cycle.
- busy and done are never high together.
- Back-to-back: start held high in DONE restarts on the next edge. The minimum period is n+2 cycles per result.

## Configuration
- FIBONACCI_OVERFLOW_EN defined: ova/ovb tracking is compiled in, and overflow reports wrap as described.
- Not defined: the flag registers are removed and overflow is tied to 0. fibo_out is still F(n) mod 2^DATA_W.

## Structure
- Package fibonacci_pkg holds:
  - the state typedef (IDLE, RUN, DONE)
  - the reset constants for a and b (0, 1)
- One sub-module, fibonacci_step. It is combinational and takes a, b, ova, ovb. It returns next a, next b and next flags, including the carry-out.
- The FSM and registers stay in fibonacci_engine.

## Test plan
- Reset, then start with n=0 → done after 1 cycle, fibo_out=0, overflow=0. Then n=1 → fibo_out=1 after 2 cycles.
- n=10 → busy for 11 cycles, then done=1, fibo_out=55. Holding start=0 for 20 cycles keeps 55 and done=1.
- Default widths:
  - n=24 → 46368, overflow=0.
  - n=25 → 9489 (75025 mod 65536); overflow=1 with the macro, 0 without.
- DATA_W=8, IDX_W=4:
  - n=13 → 233, overflow=0.
  - n=14 → 121, overflow=1 (macro on).
  - n=15 → 98.
- n=20 started, then start pulsed with n_in=3 mid-RUN → ignored; result 6765.
- Reset asserted mid-run (n=20, cycle 7) → outputs 0 immediately. Next start with n=5 → 5.
- Back-to-back: in DONE (n=7 → 13), start=1 with n=12 → done drops next cycle, then 144 after 13 cycles.

Source files
------------

// File: rtl/fibonacci_pkg.sv
// Shared types and reset constants for the Fibonacci engine.
package fibonacci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned A_RST = 0;
  localparam int unsigned B_RST = 1;

endpackage

// File: rtl/fibonacci_step.sv
// One combinational Fibonacci step: (a, b) -> (b, a+b) with optional wrap tracking.
// Wrap flags and carry are present only when FIBONACCI_OVERFLOW_EN is defined.
module fibonacci_step
  import fibonacci_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
`ifdef FIBONACCI_OVERFLOW_EN
  input  logic              ova_i,
  input  logic              ovb_i,
  output logic              ova_o,
  output logic              ovb_o,
  output logic              carry_o,
`endif
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o
);

`ifdef FIBONACCI_OVERFLOW_EN
  logic [DATA_W:0] sum;

  // Widened add; the carry feeds only the sticky wrap flags.
  assign sum     = {1'b0, a_i} + {1'b0, b_i};
  assign a_o     = b_i;
  assign b_o     = sum[DATA_W-1:0];
  assign carry_o = sum[DATA_W];
  assign ova_o   = ovb_i;
  assign ovb_o   = ova_i | ovb_i | sum[DATA_W];
`else
  assign a_o = b_i;
  assign b_o = a_i + b_i;
`endif

endmodule

// File: rtl/fibonacci_engine.sv
// Fibonacci engine: computes F(n) mod 2^DATA_W under a start/busy/done handshake.
// Define FIBONACCI_OVERFLOW_EN to compile in overflow detection.
module fibonacci_engine
  import fibonacci_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] fibo_out,
  output logic              overflow
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]    k_q, k_d, n_q, n_d;
  logic [DATA_W-1:0]   fibo_q, fibo_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]   a_step, b_step;

`ifdef FIBONACCI_OVERFLOW_EN
  logic ova_q, ova_d, ovb_q, ovb_d;
  logic ovf_q, ovf_d;
  logic ova_step, ovb_step, carry_step;

  fibonacci_step #(.DATA_W(DATA_W)) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .ova_i   (ova_q),
    .ovb_i   (ovb_q),
    .ova_o   (ova_step),
    .ovb_o   (ovb_step),
    .carry_o (carry_step),
    .a_o     (a_step),
    .b_o     (b_step)
  );
`else
  fibonacci_step #(.DATA_W(DATA_W)) u_step (
    .a_i (a_q),
    .b_i (b_q),
    .a_o (a_step),
    .b_o (b_step)
  );
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      fibo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIBONACCI_OVERFLOW_EN
      ova_q   <= 1'b0;
      ovb_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      n_q     <= n_d;
      fibo_q  <= fibo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIBONACCI_OVERFLOW_EN
      ova_q   <= ova_d;
      ovb_q   <= ovb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    n_d     = n_q;
    fibo_d  = fibo_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef FIBONACCI_OVERFLOW_EN
    ova_d   = ova_q;
    ovb_d   = ovb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          n_d     = n_in;
          a_d     = DATA_W'(A_RST);
          b_d     = DATA_W'(B_RST);
          k_d     = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef FIBONACCI_OVERFLOW_EN
          ova_d   = 1'b0;
          ovb_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (k_q == n_q) begin
          state_d = DONE;
          fibo_d  = a_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef FIBONACCI_OVERFLOW_EN
          ovf_d   = ova_q;
`endif
        end else begin
          a_d = a_step;
          b_d = b_step;
          k_d = k_q + IDX_W'(1);
`ifdef FIBONACCI_OVERFLOW_EN
          ova_d = ova_step;
          ovb_d = ovb_step;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fibo_out = fibo_q;
`ifdef FIBONACCI_OVERFLOW_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fibonacci_engine.sv
// Self-checking bench for fibonacci_engine: default 16/5 instance and an 8/4 instance.
module tb_fibonacci_engine;

`ifdef FIBONACCI_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [4:0]  n0 = '0;
  logic [3:0]  n1 = '0;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [15:0] fibo0;
  logic [7:0]  fibo1;

  int total = 0;
  int bad   = 0;

  fibonacci_engine #(.DATA_W(16), .IDX_W(5)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .n_in(n0),
    .busy(busy0), .done(done0), .fibo_out(fibo0), .overflow(ovf0)
  );

  fibonacci_engine #(.DATA_W(8), .IDX_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .n_in(n1),
    .busy(busy1), .done(done1), .fibo_out(fibo1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int n;
    int val;
    bit ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic longint fib(input int n);
    longint a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic bit dn(input int sel);
    return (sel != 0) ? done1 : done0;
  endfunction

  function automatic bit bz(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction

  function automatic int fv(input int sel);
    return (sel != 0) ? 32'(fibo1) : 32'(fibo0);
  endfunction

  function automatic bit ov(input int sel);
    return (sel != 0) ? ovf1 : ovf0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_only(input int sel, input int n);
    @(negedge clk);
    if (sel != 0) begin start1 = 1'b1; n1 = 4'(n); end
    else          begin start0 = 1'b1; n0 = 5'(n); end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Cycles counted from the accepting edge; done expected at count n+1.
  task automatic wait_done(input int sel, output int lat, output int busyc);
    bit excl = 1'b0;
    lat = 0;
    busyc = 0;
    while (!dn(sel) && lat < 200) begin
      if (bz(sel)) busyc++;
      if (bz(sel) && dn(sel)) excl = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (bz(sel) && dn(sel)) excl = 1'b1;
    check("timeout", int'(lat < 200), 1);
    check("busy_done_exclusive", int'(excl), 0);
  endtask

  task automatic run(input int sel, input int n, output int lat, output int busyc);
    start_only(sel, n);
    wait_done(sel, lat, busyc);
  endtask

  initial begin
    int lat, busyc, n, w;
    longint f;

    vecs[0] = '{0, 0, 0, 1'b0};
    vecs[1] = '{0, 1, 1, 1'b0};
    vecs[2] = '{0, 10, 55, 1'b0};
    vecs[3] = '{0, 24, 46368, 1'b0};
    vecs[4] = '{0, 25, 9489, OVF_ON};
    vecs[5] = '{1, 13, 233, 1'b0};
    vecs[6] = '{1, 14, 121, OVF_ON};
    vecs[7] = '{1, 15, 98, OVF_ON};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_fibo", fv(0), 0);
    check("rst_ovf", int'(ovf0), 0);
    check("rst_done1", int'(done1), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].sel, vecs[i].n, lat, busyc);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].n + 1);
      check($sformatf("vec%0d_busy_cycles", i), busyc, vecs[i].n + 1);
      check($sformatf("vec%0d_value", i), fv(vecs[i].sel), vecs[i].val);
      check($sformatf("vec%0d_overflow", i), int'(ov(vecs[i].sel)), int'(vecs[i].ovf));
    end

    // Result holds in DONE while start stays low.
    run(0, 10, lat, busyc);
    check("hold_busy_cycles", busyc, 11);
    repeat (20) @(negedge clk);
    check("hold_done", int'(done0), 1);
    check("hold_value", fv(0), 55);
    check("hold_busy", int'(busy0), 0);

    // Start pulse during RUN is ignored.
    start_only(0, 20);
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    n0 = 5'd3;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, lat, busyc);
    check("ignore_latency", lat + 4, 21);
    check("ignore_value", fv(0), 6765);

    // Asynchronous reset in the middle of a run.
    start_only(0, 20);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy0), 0);
    check("midrst_done", int'(done0), 0);
    check("midrst_fibo", fv(0), 0);
    check("midrst_ovf", int'(ovf0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_no_result", int'(done0), 0);
    run(0, 5, lat, busyc);
    check("after_rst_latency", lat, 6);
    check("after_rst_value", fv(0), 5);

    // Back-to-back restart from DONE.
    run(0, 7, lat, busyc);
    check("b2b_first_value", fv(0), 13);
    start_only(0, 12);
    check("b2b_done_drop", int'(done0), 0);
    check("b2b_busy_rise", int'(busy0), 1);
    wait_done(0, lat, busyc);
    check("b2b_latency", lat, 13);
    check("b2b_value", fv(0), 144);

    // Random indices against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = i % 2;
      w = (sel != 0) ? 8 : 16;
      n = (sel != 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 31));
      f = fib(n);
      run(sel, n, lat, busyc);
      check($sformatf("rnd%0d_n%0d_latency", i, n), lat, n + 1);
      check($sformatf("rnd%0d_n%0d_value", i, n), fv(sel), int'(f % (64'sd1 << w)));
      check($sformatf("rnd%0d_n%0d_overflow", i, n), int'(ov(sel)),
            int'(OVF_ON && (f >= (64'sd1 << w))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
